matrix_entry_unit: RTL and testbench

Board-side input loader for the 4x4 matrix datapath, and the counterpart of the 7-segment result display. It takes element values from the slide switches and commits one element per debounced ENTER key press, in row-major order. When all 16 elements are entered, it packs them into four 128-bit row vectors. It then offers the matrix to the vector core over a valid/ready handshake.

---
 rtl/matrix_io_pkg.sv | 13 +
 rtl/matrix_entry_unit_if.sv | 21 ++
 rtl/key_debouncer.sv | 44 ++++
 rtl/matrix_entry_unit.sv | 93 +++++++++
 tb/tb_matrix_entry_unit.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_io_pkg.sv
// Shared types for the 4x4 matrix I/O path (entry loader and result display).
// Pure declarations: no latency, no flow control.
package matrix_io_pkg;
    localparam int MAT_N  = 4;
    localparam int ELEM_W = 32;

    typedef logic [MAT_N*ELEM_W-1:0] row_vec_t;

    typedef enum logic {
        COLLECT = 1'b0,
        OFFER   = 1'b1
    } entry_state_t;
endpackage

// File: rtl/matrix_entry_unit_if.sv
// Matrix handoff bundle: four packed rows plus valid/ready.
// Master holds matrix and valid steady until ready is seen with valid.
interface matrix_entry_unit_if #(
    parameter int ELEM_W = 32
);
    logic [matrix_io_pkg::MAT_N-1:0][matrix_io_pkg::MAT_N*ELEM_W-1:0] matrix;
    logic                                                              matrix_valid;
    logic                                                              matrix_ready;

    modport master (
        output matrix,
        output matrix_valid,
        input  matrix_ready
    );

    modport slave (
        input  matrix,
        input  matrix_valid,
        output matrix_ready
    );
endinterface

// File: rtl/key_debouncer.sv
// Active-low key synchronizer and debouncer; press pulse 2+DEBOUNCE_CYCLES+1 cycles after a stable press.
// No backpressure: emits exactly one single-cycle pulse per accepted press, none on release.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_meta;
    logic             key_sync;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            level    <= 1'b1;
            level_q  <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
            level_q  <= level;
            press    <= level_q & ~level;
            // Any sample matching the accepted level restarts the stability window.
            if (key_sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= key_sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/matrix_entry_unit.sv
// Loads 16 switch values row-major on debounced ENTER, then offers the packed matrix; write visible 1 cycle after the pulse.
// Holds matrix/valid frozen while offering until ready; key presses are ignored during the offer.
module matrix_entry_unit #(
    parameter int ELEM_W          = 32,
    parameter int SW_W            = 10,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SW_W-1:0]     sw,
    input  logic                key_enter_n,
    input  logic                key_clear_n,
    matrix_entry_unit_if.master bus,
    output logic [3:0]          elem_idx,
    output logic [SW_W-1:0]     cur_value
);
    import matrix_io_pkg::*;

    logic [SW_W-1:0] sw_meta;
    logic            enter_pulse;
    logic            clear_pulse;
    entry_state_t    state;

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta   <= '0;
            cur_value <= '0;
        end else begin
            sw_meta   <= sw;
            cur_value <= sw_meta;
        end
    end

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_db (
        .clk   (clk),
        .reset (reset),
        .key_n (key_enter_n),
        .press (enter_pulse)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_db (
        .clk   (clk),
        .reset (reset),
        .key_n (key_clear_n),
        .press (clear_pulse)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= COLLECT;
            bus.matrix       <= '0;
            bus.matrix_valid <= 1'b0;
            elem_idx         <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    // Clear takes priority so a simultaneous enter never lands in a wiped matrix.
                    if (clear_pulse) begin
                        bus.matrix <= '0;
                        elem_idx   <= '0;
                    end else if (enter_pulse) begin
                        for (int r = 0; r < MAT_N; r++) begin
                            for (int c = 0; c < MAT_N; c++) begin
                                if (elem_idx == 4'(r*MAT_N + c)) begin
                                    bus.matrix[r][ELEM_W*c +: ELEM_W] <= ELEM_W'(cur_value);
                                end
                            end
                        end
                        elem_idx <= elem_idx + 4'd1;
                        if (elem_idx == 4'd15) begin
                            state            <= OFFER;
                            bus.matrix_valid <= 1'b1;
                        end
                    end
                end
                OFFER: begin
                    if (bus.matrix_ready) begin
                        state            <= COLLECT;
                        bus.matrix_valid <= 1'b0;
                    end
                end
                default: begin
                    state            <= COLLECT;
                    bus.matrix_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_entry_unit.sv
// Randomized scoreboard bench for matrix_entry_unit with a 4-cycle debounce window.
module tb_matrix_entry_unit;
    localparam int DB = 4;

    typedef struct packed {
        logic [3:0]        idx;
        logic              valid;
        logic [3:0][127:0] mat;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] sw = '0;
    logic       key_enter_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic [3:0] elem_idx;
    logic [9:0] cur_value;

    matrix_entry_unit_if #(.ELEM_W(32)) bus ();

    matrix_entry_unit #(
        .ELEM_W          (32),
        .SW_W            (10),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .key_enter_n (key_enter_n),
        .key_clear_n (key_clear_n),
        .bus         (bus),
        .elem_idx    (elem_idx),
        .cur_value   (cur_value)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    snap_t exp_q[$];
    snap_t last_exp = '0;

    // Behavioural model: a flat list of 16 elements, a write index and an offer flag.
    logic [31:0] mdl [16];
    int          m_idx = 0;
    bit          m_offer = 1'b0;

    function automatic snap_t model_snap();
        snap_t s;
        s = '0;
        for (int i = 0; i < 16; i++) s.mat[i/4][32*(i%4) +: 32] = mdl[i];
        s.idx   = 4'(m_idx);
        s.valid = m_offer;
        return s;
    endfunction

    task automatic publish();
        snap_t s;
        s = model_snap();
        if (s !== last_exp) begin
            exp_q.push_back(s);
            last_exp = s;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        m_idx   = 0;
        m_offer = 1'b0;
        publish();
    endtask

    task automatic model_key(input bit ent, input bit clr, input logic [31:0] v);
        if (m_offer) return;
        if (clr) begin
            for (int i = 0; i < 16; i++) mdl[i] = '0;
            m_idx = 0;
        end else if (ent) begin
            mdl[m_idx] = v;
            m_idx++;
            if (m_idx == 16) begin
                m_idx   = 0;
                m_offer = 1'b1;
            end
        end
        publish();
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic press(input bit ent, input bit clr, input logic [9:0] v);
        sw = v;
        repeat (3) @(posedge clk);
        #1;
        check("cur_value", 512'(cur_value), 512'(v));
        model_key(ent, clr, {22'd0, v});
        if (m_offer && bus.matrix_ready) begin
            m_offer = 1'b0;
            publish();
        end
        if (ent) key_enter_n = 1'b0;
        if (clr) key_clear_n = 1'b0;
        repeat ($urandom_range(9, 12)) @(posedge clk);
        #1;
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        drain();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_idx", 512'(elem_idx), 0);
        check("rst_valid", 512'(bus.matrix_valid), 0);
        check("rst_matrix", bus.matrix, '0);
        drain();
    endtask

    task automatic handshake();
        @(posedge clk);
        #1;
        bus.matrix_ready = 1'b1;
        m_offer = 1'b0;
        publish();
        @(posedge clk);
        #1;
        bus.matrix_ready = 1'b0;
        @(negedge clk);
        check("hs_valid_drop", 512'(bus.matrix_valid), 0);
        check("hs_idx", 512'(elem_idx), 0);
        drain();
    endtask

    // Monitor: every visible change of the DUT outputs must match the next expected snapshot.
    initial begin
        snap_t prev;
        snap_t cur;
        snap_t want;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {elem_idx, bus.matrix_valid, bus.matrix};
            if (mon_en && cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mon_unexpected_change idx=%0d valid=%0b mat=%0h required no change",
                             cur.idx, cur.valid, cur.mat);
                end else begin
                    want = exp_q.pop_front();
                    if (cur !== want) begin
                        errors++;
                        $display("FAIL mon_snapshot idx=%0d valid=%0b mat=%0h required idx=%0d valid=%0b mat=%0h",
                                 cur.idx, cur.valid, cur.mat, want.idx, want.valid, want.mat);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [3:0][127:0] fl;
        bus.matrix_ready = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;

        // Reset held 3 cycles with noisy switches.
        reset = 1'b1;
        sw = 10'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_matrix", bus.matrix, '0);
        check("reset_valid", 512'(bus.matrix_valid), 0);
        check("reset_idx", 512'(elem_idx), 0);
        check("reset_cur_value", 512'(cur_value), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // Clean press with exact latency.
        sw = 10'd5;
        repeat (3) @(posedge clk);
        #1;
        model_key(1'b1, 1'b0, 32'd5);
        key_enter_n = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i == 7) check("press_latency_before", 512'(elem_idx), 0);
            if (i == 8) begin
                check("press_latency_idx", 512'(elem_idx), 1);
                check("press_latency_elem", 512'(bus.matrix[0][31:0]), 5);
            end
        end
        @(posedge clk);
        #1;
        key_enter_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        drain();

        // Seven elements then clear; then simultaneous clear and enter.
        for (int k = 0; k < 6; k++) press(1'b1, 1'b0, 10'($urandom_range(1, 1023)));
        check("clear_pre_idx", 512'(elem_idx), 7);
        press(1'b0, 1'b1, 10'($urandom));
        check("clear_idx", 512'(elem_idx), 0);
        for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 10'($urandom_range(1, 1023)));
        press(1'b1, 1'b1, 10'($urandom_range(1, 1023)));
        check("both_idx", 512'(elem_idx), 0);
        check("both_matrix", bus.matrix, '0);

        // Full-width switch value must be zero-extended.
        press(1'b1, 1'b0, 10'h3FF);
        check("width_elem", 512'(bus.matrix[0][31:0]), 512'(32'h0000_03FF));
        press(1'b0, 1'b1, 10'd0);

        // Bounce on press gives one write; bounce on release gives none.
        sw = 10'($urandom_range(1, 1023));
        repeat (3) @(posedge clk);
        #1;
        model_key(1'b1, 1'b0, {22'd0, sw});
        for (int i = 0; i < 10; i++) begin
            key_enter_n = i[0] ? 1'b1 : 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        key_enter_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            key_enter_n = i[0] ? 1'b0 : 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
        key_enter_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        drain();
        check("bounce_idx", 512'(elem_idx), 1);
        press(1'b0, 1'b1, 10'd0);

        // Full load 1..16 with ready low, presses ignored while offering.
        for (int k = 1; k <= 16; k++) press(1'b1, 1'b0, 10'(k));
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) fl[r][32*c +: 32] = 32'(4*r + c + 1);
        check("load_valid", 512'(bus.matrix_valid), 1);
        check("load_matrix", bus.matrix, fl);
        press(1'b1, 1'b0, 10'($urandom));
        press(1'b0, 1'b1, 10'($urandom));
        check("offer_frozen", bus.matrix, fl);
        check("offer_valid_held", 512'(bus.matrix_valid), 1);
        handshake();

        // Ready held high: one-cycle offer, then partial re-entry overwrites in order.
        bus.matrix_ready = 1'b1;
        for (int k = 0; k < 16; k++) press(1'b1, 1'b0, 10'($urandom));
        check("ready_high_valid", 512'(bus.matrix_valid), 0);
        press(1'b1, 1'b0, 10'($urandom));
        press(1'b1, 1'b0, 10'($urandom));
        check("reentry_matrix", bus.matrix, model_snap().mat);
        bus.matrix_ready = 1'b0;

        // Reset mid-load at nine elements, then reset while offering.
        for (int k = 0; k < 7; k++) press(1'b1, 1'b0, 10'($urandom));
        check("midload_idx", 512'(elem_idx), 9);
        do_reset();
        for (int k = 0; k < 16; k++) press(1'b1, 1'b0, 10'($urandom));
        check("offer_before_reset", 512'(bus.matrix_valid), 1);
        do_reset();

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
